noc_flit_link_arbiter: RTL and testbench

//  Wormhole arbiter that shares one router input link between NREQ packet-generator

---
 rtl/noc_flit_link_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_noc_flit_link_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_link_arbiter.sv
// noc_flit_link_arbiter
//   Wormhole arbiter sharing one router input link between NREQ flit
//   generators. A winner is picked per packet in round-robin order, and the
//   link stays locked to it from its header flit to its tail flit. Flits
//   pass through a single registered output stage. A watchdog releases a
//   lock whose owner has stopped sending.
//
//   Flit type is flit[FW-1:FW-2]: 11 header, 10 payload, 01 tail, 00 idle.
//
//   Handshake (all links): a flit moves on a rising edge where valid and
//   ready are both 1. A sender holds its flit stable while valid=1 and
//   ready=0. Ready never depends on the flit being accepted in that cycle.
//
// Ports
//   clk, rst      clock (rising edge); asynchronous active-low reset
//   in_flit       NREQ flits packed, requester i = [i*FW +: FW]
//   in_valid      per-requester flit valid
//   in_ready      per-requester accept
//   out_flit      registered flit to the router
//   out_valid     out_flit valid
//   out_ready     router accepts out_flit
//   grant         one-hot owner while locked, 0 while idle
//   err_hdr       level: a valid non-header flit from a requester that does not own the link
//   err_timeout   one-cycle pulse after a watchdog lock release
//   dbg_state     FSM state (0 idle, 1 locked)
module noc_flit_link_arbiter #(
   parameter int FW        = 40,
   parameter int NREQ      = 4,
   parameter int TO_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ*FW-1:0]   in_flit,
   input  logic [NREQ-1:0]      in_valid,
   output logic [NREQ-1:0]      in_ready,
   output logic [FW-1:0]        out_flit,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NREQ-1:0]      grant,
   output logic                 err_hdr,
   output logic                 err_timeout,
   output logic                 dbg_state
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TO_CYCLES) + 1;

   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t          r_state, w_state_nxt;
   logic [PW-1:0]   r_ptr, r_owner;
   logic [CW-1:0]   r_stall_cnt, w_stall_nxt;
   logic [FW-1:0]   r_out_flit;
   logic            r_out_valid, r_err_timeout;

   logic [NREQ-1:0] w_hdr, w_bad, w_ready;
   logic [PW-1:0]   w_winner, w_idx;
   logic            w_found;
   logic [FW-1:0]   w_own_flit, w_win_flit, w_load_flit;
   logic            w_own_valid;
   logic [1:0]      w_own_type;
   logic            w_space, w_load, w_take, w_timeout, w_err_hdr;

   // Classify each requester's presented flit.
   always_comb begin
      w_hdr = '0;
      w_bad = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_hdr[i] = in_valid[i] & (in_flit[i*FW+FW-2 +: 2] == 2'b11);
         w_bad[i] = in_valid[i] & (in_flit[i*FW+FW-2 +: 2] != 2'b11);
      end
   end

   // Round-robin search starting just after the last winner, wrapping mod NREQ.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_ptr;
      w_idx    = r_ptr;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = (w_idx == PW'(NREQ-1)) ? '0 : w_idx + PW'(1);
         if (!w_found && w_hdr[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   // Flit muxes for the current owner and the arbitration winner.
   always_comb begin
      w_own_flit = '0;
      w_win_flit = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == r_owner)  w_own_flit = in_flit[i*FW +: FW];
         if (PW'(i) == w_winner) w_win_flit = in_flit[i*FW +: FW];
      end
   end

   assign w_own_valid = in_valid[r_owner];
   assign w_own_type  = w_own_flit[FW-1:FW-2];
   assign w_space     = !r_out_valid | out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = '0;
      w_load      = 1'b0;
      w_load_flit = w_own_flit;
      w_take      = 1'b0;
      w_stall_nxt = r_stall_cnt;
      w_timeout   = 1'b0;
      w_err_hdr   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_err_hdr   = |w_bad;
            w_stall_nxt = '0;
            if (w_found && w_space) begin
               w_ready[w_winner] = 1'b1;
               w_take            = 1'b1;
               w_load            = 1'b1;
               w_load_flit       = w_win_flit;
               w_state_nxt       = S_LOCKED;
            end
         end
         S_LOCKED: begin
            for (int i = 0; i < NREQ; i++)
               if (PW'(i) != r_owner && w_bad[i]) w_err_hdr = 1'b1;
            w_ready[r_owner] = w_space;
            if (w_own_valid) begin
               // A valid owner blocked only by the output stage is not a stall.
               if (w_space) begin
                  w_stall_nxt = '0;
                  w_load      = (w_own_type != 2'b00);
                  if (w_own_type == 2'b01) w_state_nxt = S_IDLE;
               end
            end else if (r_stall_cnt == CW'(TO_CYCLES-1)) begin
               w_timeout   = 1'b1;
               w_stall_nxt = '0;
               w_state_nxt = S_IDLE;
            end else if (r_stall_cnt != '1) begin
               w_stall_nxt = r_stall_cnt + CW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_flit    <= '0;
         r_out_valid   <= 1'b0;
         r_ptr         <= PW'(NREQ-1);
         r_owner       <= '0;
         r_stall_cnt   <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         if (w_load) begin
            r_out_flit  <= w_load_flit;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_take) begin
            r_ptr   <= w_winner;
            r_owner <= w_winner;
         end
         r_stall_cnt   <= w_stall_nxt;
         r_err_timeout <= w_timeout;
      end
   end

   always_comb begin
      grant = '0;
      if (r_state == S_LOCKED) grant[r_owner] = 1'b1;
   end

   // Nothing is accepted while reset is held.
   assign in_ready    = w_ready & {NREQ{rst}};
   assign out_flit    = r_out_flit;
   assign out_valid   = r_out_valid;
   assign err_hdr     = w_err_hdr;
   assign err_timeout = r_err_timeout;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_noc_flit_link_arbiter.sv
// Directed bench for noc_flit_link_arbiter (FW=40, NREQ=4, TO_CYCLES=16).
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, so registered outputs show the result of the previous rising edge
// and combinational outputs reflect the inputs of the current cycle.
module tb_noc_flit_link_arbiter;

   localparam logic [1:0] H = 2'b11;
   localparam logic [1:0] P = 2'b10;
   localparam logic [1:0] T = 2'b01;
   localparam logic [1:0] I = 2'b00;

   logic         clk;
   logic         rst;
   logic [159:0] in_flit;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [39:0]  out_flit;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   grant;
   logic         err_hdr;
   logic         err_timeout;
   logic         dbg_state;

   int n_checks = 0;
   int n_err    = 0;

   noc_flit_link_arbiter #(.FW(40), .NREQ(4), .TO_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
      .in_ready(in_ready), .out_flit(out_flit), .out_valid(out_valid),
      .out_ready(out_ready), .grant(grant), .err_hdr(err_hdr),
      .err_timeout(err_timeout), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic reset_dut();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- driver ----------------
   function automatic logic [39:0] mk(input logic [1:0] t, input logic [3:0] r, input logic [3:0] s);
      return {t, 30'd0, r, s};
   endfunction

   // ty = {type3, type2, type1, type0}; every requester carries the same seq tag.
   task automatic drive(input logic [3:0] vld, input logic [7:0] ty, input logic [3:0] seq,
                        input logic ordy);
      @(negedge clk);
      in_valid  = vld;
      out_ready = ordy;
      for (int i = 0; i < 4; i++) in_flit[i*40 +: 40] = mk(ty[2*i +: 2], 4'(i), seq);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst_before;
      logic [3:0] vld;
      logic [7:0] ty;
      logic [3:0] seq;
      logic       ordy;
      logic [3:0] erdy;
      logic       eov;
      logic [1:0] eft;
      logic [3:0] ereq;
      logic [3:0] eseq;
      logic [3:0] egnt;
      logic       ehdr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rb, input logic [3:0] vld, input logic [7:0] ty,
                      input logic [3:0] seq, input logic ordy, input logic [3:0] erdy,
                      input logic eov, input logic [1:0] eft, input logic [3:0] ereq,
                      input logic [3:0] eseq, input logic [3:0] egnt, input logic ehdr);
      vec_t v;
      v.rst_before = rb; v.vld = vld; v.ty = ty; v.seq = seq; v.ordy = ordy;
      v.erdy = erdy; v.eov = eov; v.eft = eft; v.ereq = ereq; v.eseq = eseq;
      v.egnt = egnt; v.ehdr = ehdr;
      vecs.push_back(v);
   endtask

   // ---------------- scoreboard for output flits ----------------
   logic [39:0] exp_q[$];

   initial begin
      rst       = 1'b0;
      in_valid  = 4'hF;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_flit[i*40 +: 40] = mk(H, 4'(i), 4'd0);

      // Reset held with every requester presenting a header.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk("rst out_valid", 64'(out_valid), 64'd0);
         chk("rst grant", 64'(grant), 64'd0);
         chk("rst in_ready", 64'(in_ready), 64'd0);
         chk("rst err_timeout", 64'(err_timeout), 64'd0);
      end
      @(negedge clk);
      in_valid = '0;
      rst      = 1'b1;

      // Single packet from req2: H,P,P,T back-to-back.
      add(1, 4'b0100, {I,H,I,I}, 0, 1, 4'b0100, 0, I, 0, 0, 4'b0000, 0);
      add(0, 4'b0100, {I,P,I,I}, 1, 1, 4'b0100, 1, H, 2, 0, 4'b0100, 0);
      add(0, 4'b0100, {I,P,I,I}, 2, 1, 4'b0100, 1, P, 2, 1, 4'b0100, 0);
      add(0, 4'b0100, {I,T,I,I}, 3, 1, 4'b0100, 1, P, 2, 2, 4'b0100, 0);
      add(0, 4'b0000, {I,I,I,I}, 0, 1, 4'b0000, 1, T, 2, 3, 4'b0000, 0);
      add(0, 4'b0000, {I,I,I,I}, 0, 1, 4'b0000, 0, I, 0, 0, 4'b0000, 0);
      // Round robin, each requester streaming 2-flit packets: order 0,1,2,3,0.
      add(1, 4'b1111, {H,H,H,H}, 0, 1, 4'b0001, 0, I, 0, 0, 4'b0000, 0);
      add(0, 4'b1111, {H,H,H,T}, 0, 1, 4'b0001, 1, H, 0, 0, 4'b0001, 0);
      add(0, 4'b1111, {H,H,H,H}, 0, 1, 4'b0010, 1, T, 0, 0, 4'b0000, 0);
      add(0, 4'b1111, {H,H,T,H}, 0, 1, 4'b0010, 1, H, 1, 0, 4'b0010, 0);
      add(0, 4'b1111, {H,H,H,H}, 0, 1, 4'b0100, 1, T, 1, 0, 4'b0000, 0);
      add(0, 4'b1111, {H,T,H,H}, 0, 1, 4'b0100, 1, H, 2, 0, 4'b0100, 0);
      add(0, 4'b1111, {H,H,H,H}, 0, 1, 4'b1000, 1, T, 2, 0, 4'b0000, 0);
      add(0, 4'b1111, {T,H,H,H}, 0, 1, 4'b1000, 1, H, 3, 0, 4'b1000, 0);
      add(0, 4'b1111, {H,H,H,H}, 0, 1, 4'b0001, 1, T, 3, 0, 4'b0000, 0);
      add(0, 4'b1111, {H,H,H,T}, 0, 1, 4'b0001, 1, H, 0, 0, 4'b0001, 0);
      // Lock hold: req0 header waits behind req1; an idle flit from req1 is dropped.
      add(1, 4'b0010, {I,I,H,I}, 0, 1, 4'b0010, 0, I, 0, 0, 4'b0000, 0);
      add(0, 4'b0011, {I,I,P,H}, 1, 1, 4'b0010, 1, H, 1, 0, 4'b0010, 0);
      add(0, 4'b0011, {I,I,I,H}, 2, 1, 4'b0010, 1, P, 1, 1, 4'b0010, 0);
      add(0, 4'b0011, {I,I,P,H}, 3, 1, 4'b0010, 0, I, 0, 0, 4'b0010, 0);
      add(0, 4'b0011, {I,I,T,H}, 4, 1, 4'b0010, 1, P, 1, 3, 4'b0010, 0);
      add(0, 4'b0001, {I,I,I,H}, 5, 1, 4'b0001, 1, T, 1, 4, 4'b0000, 0);
      add(0, 4'b0001, {I,I,I,T}, 6, 1, 4'b0001, 1, H, 0, 5, 4'b0001, 0);
      add(0, 4'b0000, {I,I,I,I}, 0, 1, 4'b0000, 1, T, 0, 6, 4'b0000, 0);
      add(0, 4'b0000, {I,I,I,I}, 0, 1, 4'b0000, 0, I, 0, 0, 4'b0000, 0);
      // Backpressure: out_ready=0 for 5 cycles mid-packet from req2.
      add(1, 4'b0100, {I,H,I,I}, 0, 1, 4'b0100, 0, I, 0, 0, 4'b0000, 0);
      add(0, 4'b0100, {I,P,I,I}, 1, 1, 4'b0100, 1, H, 2, 0, 4'b0100, 0);
      for (int c = 0; c < 5; c++)
         add(0, 4'b0100, {I,P,I,I}, 2, 0, 4'b0000, 1, P, 2, 1, 4'b0100, 0);
      add(0, 4'b0100, {I,P,I,I}, 2, 1, 4'b0100, 1, P, 2, 1, 4'b0100, 0);
      add(0, 4'b0100, {I,T,I,I}, 3, 1, 4'b0100, 1, P, 2, 2, 4'b0100, 0);
      add(0, 4'b0000, {I,I,I,I}, 0, 1, 4'b0000, 1, T, 2, 3, 4'b0000, 0);
      add(0, 4'b0000, {I,I,I,I}, 0, 1, 4'b0000, 0, I, 0, 0, 4'b0000, 0);

      for (int r = 0; r < vecs.size(); r++) begin
         if (vecs[r].rst_before) reset_dut();
         drive(vecs[r].vld, vecs[r].ty, vecs[r].seq, vecs[r].ordy);
         #1;
         chk($sformatf("row%0d in_ready", r), 64'(in_ready), 64'(vecs[r].erdy));
         chk($sformatf("row%0d out_valid", r), 64'(out_valid), 64'(vecs[r].eov));
         chk($sformatf("row%0d grant", r), 64'(grant), 64'(vecs[r].egnt));
         chk($sformatf("row%0d err_hdr", r), 64'(err_hdr), 64'(vecs[r].ehdr));
         chk($sformatf("row%0d err_timeout", r), 64'(err_timeout), 64'd0);
         if (vecs[r].eov)
            chk($sformatf("row%0d out_flit", r), 64'(out_flit),
                64'(mk(vecs[r].eft, vecs[r].ereq, vecs[r].eseq)));
      end

      // Watchdog: 15 stall cycles are tolerated, the 16th releases the lock.
      reset_dut();
      drive(4'b0010, {I,I,H,I}, 0, 1); #1;
      chk("wd hdr ready", 64'(in_ready), 64'b0010);
      drive(4'b0010, {I,I,P,I}, 1, 1); #1;
      chk("wd grant", 64'(grant), 64'b0010);
      for (int k = 1; k <= 15; k++) begin
         drive(4'b0000, {I,I,I,I}, 0, 1); #1;
         chk($sformatf("wd stall%0d grant", k), 64'(grant), 64'b0010);
         chk($sformatf("wd stall%0d err_timeout", k), 64'(err_timeout), 64'd0);
      end
      drive(4'b0010, {I,I,P,I}, 2, 1); #1;
      chk("wd resume ready", 64'(in_ready), 64'b0010);
      exp_q.push_back(mk(P, 4'd1, 4'd2));
      for (int k = 1; k <= 16; k++) begin
         drive(4'b0000, {I,I,I,I}, 0, 1); #1;
         if (k == 1) begin
            chk("wd resume out_valid", 64'(out_valid), 64'd1);
            chk("wd resume out_flit", 64'(out_flit), 64'(exp_q.pop_front()));
         end
         chk($sformatf("wd2 stall%0d grant", k), 64'(grant), 64'b0010);
         chk($sformatf("wd2 stall%0d err_timeout", k), 64'(err_timeout), 64'd0);
      end
      drive(4'b0010, {I,I,P,I}, 3, 1); #1;
      chk("wd fire err_timeout", 64'(err_timeout), 64'd1);
      chk("wd fire grant", 64'(grant), 64'd0);
      chk("wd late err_hdr", 64'(err_hdr), 64'd1);
      chk("wd late in_ready", 64'(in_ready), 64'd0);
      drive(4'b0010, {I,I,P,I}, 3, 1); #1;
      chk("wd pulse end", 64'(err_timeout), 64'd0);
      chk("wd late out_valid", 64'(out_valid), 64'd0);
      chk("wd late err_hdr2", 64'(err_hdr), 64'd1);
      drive(4'b0000, {I,I,I,I}, 0, 1); #1;
      chk("wd after out_valid", 64'(out_valid), 64'd0);
      chk("wd after err_hdr", 64'(err_hdr), 64'd0);

      // Reset mid-packet drops the lock and the buffered flit at once.
      reset_dut();
      drive(4'b0001, {I,I,I,H}, 0, 1); #1;
      drive(4'b0001, {I,I,I,P}, 1, 1); #1;
      chk("mid grant", 64'(grant), 64'b0001);
      chk("mid out_valid", 64'(out_valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("mid rst out_valid", 64'(out_valid), 64'd0);
      chk("mid rst grant", 64'(grant), 64'd0);
      chk("mid rst in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      drive(4'b0010, {I,I,H,I}, 2, 1); #1;
      chk("post rst ready", 64'(in_ready), 64'b0010);
      chk("post rst out_valid", 64'(out_valid), 64'd0);
      drive(4'b0000, {I,I,I,I}, 0, 1); #1;
      chk("post rst flit", 64'(out_flit), 64'(mk(H, 4'd1, 4'd2)));
      chk("post rst grant", 64'(grant), 64'b0010);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
